// File: rtl/qam_demod_mix_pkg.sv
// rtl/qam_demod_mix_pkg.sv - shared widths, demod defaults and FSM state type
package parameter_def;

  localparam int QAM_WIDTH     = 12;
  localparam int CARRIER_WIDTH = 8;
  localparam int FILTER_WIDTH  = 10;
  localparam int DEMOD_SPS     = 16;
  localparam int DEMOD_SHIFT   = 9;

  typedef enum logic [1:0] {IDLE, ARM, RUN} demod_state_t;

endpackage

// File: rtl/qam_demod_acc.sv
// rtl/qam_demod_acc.sv - integrate-and-dump with floor shift and clamp for one branch
module qam_demod_acc
  import parameter_def::*;
#(
  parameter int P_W   = QAM_WIDTH + CARRIER_WIDTH,
  parameter int ACC_W = QAM_WIDTH + CARRIER_WIDTH + $clog2(DEMOD_SPS),
  parameter int OUT_W = FILTER_WIDTH,
  parameter int SHIFT = DEMOD_SHIFT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    in_valid,
  input  logic                    first,
  input  logic                    last,
  input  logic signed [P_W-1:0]   prod,
  output logic signed [OUT_W-1:0] result,
  output logic                    clamp
);

  localparam logic signed [ACC_W-1:0] LIM_HI = ACC_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] LIM_LO = ~LIM_HI;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] shifted;
  logic                    hi;
  logic                    lo;

  always_comb begin
    prod_ext = {{(ACC_W - P_W){prod[P_W-1]}}, prod};
    sum      = first ? prod_ext : acc + prod_ext;
    shifted  = sum >>> SHIFT;
    hi       = shifted > LIM_HI;
    lo       = shifted < LIM_LO;
    clamp    = in_valid & last & (hi | lo);
  end

  // a symbol-completing sample is still dumped even while the partial-symbol clear is active
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      result <= '0;
    end else if (in_valid) begin
      acc <= clear ? '0 : sum;
      if (last) begin
        result <= hi ? LIM_HI[OUT_W-1:0] : (lo ? LIM_LO[OUT_W-1:0] : shifted[OUT_W-1:0]);
      end
    end else if (clear) begin
      acc <= '0;
    end
  end

endmodule

// File: rtl/qam_demod_mix.sv
// rtl/qam_demod_mix.sv - coherent QAM-16 mixer, symbol integrator and dump control
module qam_demod_mix
  import parameter_def::*;
#(
  parameter int QAM_W = QAM_WIDTH,
  parameter int CAR_W = CARRIER_WIDTH,
  parameter int OUT_W = FILTER_WIDTH,
  parameter int SPS   = DEMOD_SPS,
  parameter int SHIFT = DEMOD_SHIFT
) (
  input  logic                    axi_clk,
  input  logic                    axi_rst,
  input  logic signed [QAM_W-1:0] qam_data,
  input  logic                    qam_valid,
  input  logic signed [CAR_W-1:0] cor_sin,
  input  logic signed [CAR_W-1:0] cor_cos,
  input  logic                    cor_zero,
  output logic signed [OUT_W-1:0] demod_i,
  output logic signed [OUT_W-1:0] demod_q,
  output logic                    demod_valid,
  output logic                    demod_sat
);

  localparam int P_W   = QAM_W + CAR_W;
  localparam int CNT_W = $clog2(SPS);
  localparam int ACC_W = P_W + CNT_W;

  demod_state_t state, state_next;
  logic accept, flush, kill;
  logic [CNT_W-1:0] cnt;

  logic signed [QAM_W-1:0] data_r;
  logic signed [CAR_W-1:0] cos_r, sin_r;
  logic v1, first1, last1;

  logic signed [P_W-1:0] ext_d, ext_c, ext_s, mul_i, mul_q;
  logic signed [P_W-1:0] prod_i, prod_q;
  logic v2, first2, last2;

  logic acc_valid, clamp_i, clamp_q;

  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    flush      = 1'b0;
    case (state)
      IDLE: if (qam_valid) state_next = ARM;
      ARM: begin
        if (!qam_valid) begin
          state_next = IDLE;
        end else if (cor_zero) begin
          state_next = RUN;
          accept     = 1'b1;
        end
      end
      RUN: begin
        if (qam_valid) begin
          accept = 1'b1;
        end else begin
          flush      = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // a nonzero count at the drop means the newest in-flight samples belong to a partial symbol
  assign kill = flush & (cnt != '0);

  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      cnt    <= '0;
      v1     <= 1'b0;
      first1 <= 1'b0;
      last1  <= 1'b0;
      data_r <= '0;
      cos_r  <= '0;
      sin_r  <= '0;
    end else begin
      v1 <= accept;
      if (flush) cnt <= '0;
      else if (accept) cnt <= cnt + 1'b1;
      if (accept) begin
        data_r <= qam_data;
        cos_r  <= cor_cos;
        sin_r  <= cor_sin;
        first1 <= (cnt == '0);
        last1  <= (cnt == CNT_W'(SPS - 1));
      end
    end
  end

  always_comb begin
    ext_d = {{CAR_W{data_r[QAM_W-1]}}, data_r};
    ext_c = {{QAM_W{cos_r[CAR_W-1]}}, cos_r};
    ext_s = {{QAM_W{sin_r[CAR_W-1]}}, sin_r};
    mul_i = ext_d * ext_c;
    mul_q = ext_d * ext_s;
  end

  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      v2     <= 1'b0;
      first2 <= 1'b0;
      last2  <= 1'b0;
      prod_i <= '0;
      prod_q <= '0;
    end else begin
      v2 <= v1 & ~kill;
      if (v1) begin
        prod_i <= mul_i;
        prod_q <= -mul_q;
        first2 <= first1;
        last2  <= last1;
      end
    end
  end

  assign acc_valid = v2 & (~kill | last2);

  qam_demod_acc #(.P_W(P_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_acc_i (
    .clk(axi_clk), .rst(axi_rst), .clear(kill), .in_valid(acc_valid),
    .first(first2), .last(last2), .prod(prod_i), .result(demod_i), .clamp(clamp_i)
  );

  qam_demod_acc #(.P_W(P_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_acc_q (
    .clk(axi_clk), .rst(axi_rst), .clear(kill), .in_valid(acc_valid),
    .first(first2), .last(last2), .prod(prod_q), .result(demod_q), .clamp(clamp_q)
  );

  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      demod_valid <= 1'b0;
      demod_sat   <= 1'b0;
    end else begin
      demod_valid <= acc_valid & last2;
      demod_sat   <= demod_sat | clamp_i | clamp_q;
    end
  end

endmodule

// File: tb/tb_qam_demod_mix.sv
// tb/tb_qam_demod_mix.sv - self-checking bench for qam_demod_mix
module tb_qam_demod_mix;
  import parameter_def::*;

  logic              axi_clk = 1'b0;
  logic              axi_rst = 1'b1;
  logic signed [11:0] qam_data = '0;
  logic              qam_valid = 1'b0;
  logic signed [7:0] cor_sin = '0;
  logic signed [7:0] cor_cos = '0;
  logic              cor_zero = 1'b0;
  logic signed [9:0] demod_i, demod_q;
  logic              demod_valid, demod_sat;

  always #5 axi_clk = ~axi_clk;

  qam_demod_mix dut (
    .axi_clk(axi_clk), .axi_rst(axi_rst), .qam_data(qam_data), .qam_valid(qam_valid),
    .cor_sin(cor_sin), .cor_cos(cor_cos), .cor_zero(cor_zero),
    .demod_i(demod_i), .demod_q(demod_q), .demod_valid(demod_valid), .demod_sat(demod_sat)
  );

  typedef struct {int cyc; int i; int q; bit clamp;} pulse_t;
  typedef struct {int d; int c; int s; int ei; int eq; bit esat;} row_t;

  pulse_t exp_q[$];
  pulse_t obs_q[$];
  int n_vec = 0, n_bad = 0, edge_n = 0;
  int m_mode = 0, m_cnt = 0, last_i = 0, last_q = 0;
  longint m_si = 0, m_sq = 0;
  bit m_sat = 0;

  function automatic void chk(string name, int act, int expv);
    n_vec++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, expv, edge_n);
    end
  endfunction

  function automatic int lim(longint sum);
    longint t = sum >>> 9;
    if (t > 511) return 511;
    if (t < -512) return -512;
    return int'(t);
  endfunction

  function automatic bit over(longint sum);
    longint t = sum >>> 9;
    return (t > 511) || (t < -512);
  endfunction

  // Reference: a symbol is 16 accepted samples starting at a cor_zero sample; partial symbols vanish
  function automatic void model_step(bit v, int d, int c, int s, bit z);
    if (axi_rst) return;
    case (m_mode)
      0: if (v) m_mode = 1;
      1: begin
        if (!v) m_mode = 0;
        else if (z) begin
          m_mode = 2; m_cnt = 0; m_si = 0; m_sq = 0;
        end
      end
      default: if (!v) begin m_mode = 0; m_cnt = 0; end
    endcase
    if (m_mode == 2 && v) begin
      m_si += longint'(d) * c;
      m_sq -= longint'(d) * s;
      m_cnt++;
      if (m_cnt == 16) begin
        exp_q.push_back('{edge_n + 2, lim(m_si), lim(m_sq), over(m_si) || over(m_sq)});
        m_cnt = 0; m_si = 0; m_sq = 0;
      end
    end
  endfunction

  task automatic send(bit v, int d, int c, int s, bit z);
    qam_valid = v; qam_data = 12'(d); cor_cos = 8'(c); cor_sin = 8'(s); cor_zero = z;
    @(posedge axi_clk);
    edge_n++;
    model_step(v, d, c, s, z);
    #1;
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) send(0, 0, 0, 0, 0);
  endtask

  task automatic sym(int d, int c, int s, bit z);
    for (int k = 0; k < 16; k++) send(1, d, c, s, z && (k == 0));
  endtask

  task automatic do_reset();
    #1 axi_rst = 1'b1;
    #1;
    chk("rst_demod_i", demod_i, 0);
    chk("rst_demod_q", demod_q, 0);
    chk("rst_demod_valid", demod_valid, 0);
    chk("rst_demod_sat", demod_sat, 0);
    exp_q.delete();
    m_mode = 0; m_cnt = 0; m_sat = 0; last_i = 0; last_q = 0;
    idle(2);
    axi_rst = 1'b0;
  endtask

  always @(negedge axi_clk) begin
    if (!axi_rst) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < edge_n) begin
        chk("missed_pulse_edge", edge_n, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (demod_valid) begin
        obs_q.push_back('{edge_n, int'(demod_i), int'(demod_q), demod_sat});
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse_edge", edge_n, -1);
        end else begin
          pulse_t p;
          p = exp_q.pop_front();
          chk("pulse_edge", edge_n, p.cyc);
          chk("model_demod_i", demod_i, p.i);
          chk("model_demod_q", demod_q, p.q);
          m_sat |= p.clamp;
          chk("model_demod_sat", demod_sat, m_sat);
          last_i = p.i; last_q = p.q;
        end
      end else begin
        chk("hold_demod_i", demod_i, last_i);
        chk("hold_demod_q", demod_q, last_q);
      end
    end
  end

  row_t tbl[10];
  int   e0;

  initial begin
    tbl[0] = '{100, 64, 0, 200, 0, 0};
    tbl[1] = '{100, 0, 64, 0, -200, 0};
    tbl[2] = '{1, 1, 0, 0, 0, 0};
    tbl[3] = '{-1, 1, 0, -1, 0, 0};
    tbl[4] = '{-1, 0, 1, 0, 0, 0};
    tbl[5] = '{511, 32, 0, 511, 0, 0};
    tbl[6] = '{-512, 32, 0, -512, 0, 0};
    tbl[7] = '{256, 64, 0, 511, 0, 1};
    tbl[8] = '{100, 64, 0, 200, 0, 1};
    tbl[9] = '{-2048, 127, -128, -512, -512, 1};

    do_reset();

    // back-to-back symbols from a single arm
    obs_q.delete();
    send(1, 0, 0, 0, 0);
    for (int r = 0; r < 10; r++) sym(tbl[r].d, tbl[r].c, tbl[r].s, r == 0);
    idle(4);
    chk("table_pulse_count", obs_q.size(), 10);
    for (int r = 0; r < 10 && r < obs_q.size(); r++) begin
      chk("table_demod_i", obs_q[r].i, tbl[r].ei);
      chk("table_demod_q", obs_q[r].q, tbl[r].eq);
      chk("table_demod_sat", obs_q[r].clamp, tbl[r].esat);
      if (r > 0) chk("table_spacing", obs_q[r].cyc - obs_q[r-1].cyc, 16);
    end

    // reset after 7 samples of a symbol
    send(1, 0, 0, 0, 0);
    for (int k = 0; k < 7; k++) send(1, 100, 64, 0, k == 0);
    obs_q.delete();
    do_reset();
    idle(20);
    chk("post_reset_no_pulse", obs_q.size(), 0);
    send(1, 0, 0, 0, 0);
    sym(100, 64, 0, 1);
    idle(4);
    chk("post_reset_pulses", obs_q.size(), 1);
    if (obs_q.size() > 0) chk("post_reset_demod_i", obs_q[$].i, 200);

    // 4-phase carrier, three symbols
    obs_q.delete();
    send(1, 0, 0, 0, 0);
    for (int k = 0; k < 48; k++) begin
      int ph;
      int cs[4] = '{64, 0, -64, 0};
      int sn[4] = '{0, 64, 0, -64};
      int dt[4] = '{100, -50, -100, 50};
      ph = k % 4;
      send(1, dt[ph], cs[ph], sn[ph], k == 0);
    end
    idle(4);
    chk("four_phase_pulses", obs_q.size(), 3);
    for (int r = 0; r < 3 && r < obs_q.size(); r++) begin
      chk("four_phase_i", obs_q[r].i, 100);
      chk("four_phase_q", obs_q[r].q, 50);
      if (r > 0) chk("four_phase_spacing", obs_q[r].cyc - obs_q[r-1].cyc, 16);
    end

    // ARM waits for cor_zero; samples before it are ignored
    obs_q.delete();
    send(1, 1000, 64, 0, 0);
    for (int k = 0; k < 5; k++) send(1, 1000, 64, 0, 0);
    e0 = edge_n + 1;
    sym(100, 64, 0, 1);
    idle(4);
    chk("arm_wait_pulses", obs_q.size(), 1);
    if (obs_q.size() > 0) begin
      chk("arm_wait_latency", obs_q[0].cyc, e0 + 17);
      chk("arm_wait_demod_i", obs_q[0].i, 200);
    end

    // qam_valid gap at sample 10 discards the partial symbol
    obs_q.delete();
    send(1, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) send(1, 100, 64, 0, k == 0);
    idle(20);
    chk("gap_no_pulse", obs_q.size(), 0);
    send(1, 999, 64, 0, 1);
    sym(-100, 64, 0, 1);
    idle(4);
    chk("gap_rearm_pulses", obs_q.size(), 1);
    if (obs_q.size() > 0) chk("gap_rearm_demod_i", obs_q[0].i, -200);

    // randomized traffic against the reference model
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      int d, sh;
      sh = $urandom_range(0, 4);
      d = (int'($urandom_range(0, 4095)) - 2048) >>> sh;
      send($urandom_range(0, 199) != 0, d, int'($urandom_range(0, 255)) - 128,
           int'($urandom_range(0, 255)) - 128, $urandom_range(0, 3) == 0);
    end
    idle(4);
    chk("random_pending_pulses", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
